regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Write-port scheduler and hazard scoreboard for the integer register file. Tracks which architectural registers have a write in flight, stalls issue on RAW/WAW hazards, and shares the register file's single write port between the ALU and load writeback paths with round-robin arbitration. Sits between decode/issue and `register_file`, driving that block's write address, data and enable.

## Interface
- `XLEN`, 32, data width
- `NREG`, 32, architectural register count; index width is $clog2(NREG)

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `issue_valid`  in  1  decode presents an instruction
- `issue_ready`  out  1  no hazard; issue may proceed
- `issue_rs1`, `issue_rs2`  in  5  source registers
- `issue_rd`  in  5  destination register
- `issue_writes_rd`  in  1  instruction will write `issue_rd`
- `alu_wb_valid`  in  1  ALU result ready
- `alu_wb_ready`  out  1  ALU result accepted this cycle
- `alu_wb_rd`  in  5  destination
- `alu_wb_data`  in  XLEN  result
- `mem_wb_valid`, `mem_wb_ready`, `mem_wb_rd`, `mem_wb_data`  same as ALU set, load path
- `rf_write_address`  out  5  to register file
- `rf_write_data`  out  XLEN  to register file
- `rf_write_enable`  out  1  to register file
- `busy`  out  NREG  per-register pending-write bits
- `inflight_count`  out  6  number of set bits in `busy`

## Operation
- State: `busy[NREG-1:0]`, `inflight_count`, `last_grant` (ALU or MEM).
- `busy[0]` is constant 0; x0 never stalls.
- Hazard: `busy[rs1] | busy[rs2] | (issue_writes_rd & busy[rd])`. `issue_ready = !hazard`, independent of `issue_valid`.
- Issue fires when `issue_valid & issue_ready`; if `issue_writes_rd` and rd≠0, sets `busy[rd]`.
- Arbitration: only one source valid -> that source granted. Both valid -> grant the one not equal to `last_grant`. `last_grant` updates on every grant.
- Granted source sees its ready high; it drives `rf_write_*` combinationally. `rf_write_enable = grant & (rd≠0)`.
- Grant clears `busy[rd]`. Writeback to x0 is accepted, nothing written, no busy change.
- Same-cycle issue set and writeback clear target different registers by construction (WAW stall); if both hit the same index, set wins.
- Writeback to a non-busy register: still written, busy unchanged. This is a protocol error, flagged by a simulation-only assertion.
- `inflight_count` = +1 on set, -1 on clear, net 0 on both; never exceeds 31.

## Timing
- Reset values: `busy`=0, `inflight_count`=0, `last_grant`=MEM, so ALU wins first contention. All readies follow combinationally.
- Writeback latency 0: the granted cycle's rising edge writes the register file and clears busy. Next cycle `issue_ready` reflects it and register file reads return the new value.
- No bypass: an issue reading a register being written in the same cycle stalls one cycle.
- Reset mid-operation: clears all busy bits and the count; in-flight writebacks presented after reset are accepted and written normally.
- Readies are combinational from valids and state; there are no loops through `issue_valid`.

## Structure
- Shared package `rv_pkg`: `XLEN`, `NREG`, `reg_addr_t` (logic [4:0]), `wb_src_e` {WB_ALU, WB_MEM}.
- Sub-module `wb_rr_arbiter` (2-way round-robin, valid in / grant out, holds `last_grant`).
- Top level holds the busy vector, counter and hazard logic.

## Test plan
- Reset, then idle: `busy`=0, `inflight_count`=0, `issue_ready`=1 for rs1=rs2=0.
- Issue rd=5 -> `busy[5]`=1, count=1. Next issue rs1=5 -> `issue_ready`=0. ALU wb rd=5, data=1234 -> `rf_write_enable`=1, address 5. Next cycle ready=1 and the register file reads 1234.
- Both wb valid every cycle, rd=1 then 2 (ALU) and 3 then 4 (MEM) -> grants ALU, MEM, ALU, MEM; `rf_write_address` = 1, 3, 2, 4.
- WAW: busy rd=7, issue rd=7 with `issue_writes_rd`=1 -> stall. Same with `issue_writes_rd`=0 and rs≠7 -> ready.
- Writeback rd=0, data=5678 -> `mem_wb_ready`=1, `rf_write_enable`=0, register file x0 still reads 0.
- Issue rd=9, assert `reset` before writeback -> `busy`=0, count=0; later wb rd=9 writes 9 without the count going negative.

Source files
------------

// File: rtl/rv_pkg.sv
// ============================================================================
// Module   : rv_pkg
// Brief    : Shared integer-core types: data width, register count, wb sources.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
// ============================================================================
// Module   : wb_rr_arbiter
// Brief    : Two-way round-robin grant between ALU and load writeback paths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_arbiter
  import rv_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    alu_valid,
  input  logic    mem_valid,
  output logic    alu_grant,
  output logic    mem_grant,
  output wb_src_e last_grant
);

  wb_src_e r_last_grant;
  logic    w_alu_grant;
  logic    w_mem_grant;

  // On contention the source that did not win last time gets the port.
  always_comb begin
    w_alu_grant = alu_valid & (~mem_valid | (r_last_grant == WB_MEM));
    w_mem_grant = mem_valid & (~alu_valid | (r_last_grant == WB_ALU));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= WB_MEM;
    end else if (w_alu_grant) begin
      r_last_grant <= WB_ALU;
    end else if (w_mem_grant) begin
      r_last_grant <= WB_MEM;
    end
  end

  assign alu_grant  = w_alu_grant;
  assign mem_grant  = w_mem_grant;
  assign last_grant = r_last_grant;

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : RAW/WAW hazard scoreboard and shared register-file write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREG = rv_pkg::NREG
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  rv_pkg::reg_addr_t  issue_rs1,
  input  rv_pkg::reg_addr_t  issue_rs2,
  input  rv_pkg::reg_addr_t  issue_rd,
  input  logic               issue_writes_rd,
  input  logic               alu_wb_valid,
  output logic               alu_wb_ready,
  input  rv_pkg::reg_addr_t  alu_wb_rd,
  input  logic [XLEN-1:0]    alu_wb_data,
  input  logic               mem_wb_valid,
  output logic               mem_wb_ready,
  input  rv_pkg::reg_addr_t  mem_wb_rd,
  input  logic [XLEN-1:0]    mem_wb_data,
  output rv_pkg::reg_addr_t  rf_write_address,
  output logic [XLEN-1:0]    rf_write_data,
  output logic               rf_write_enable,
  output logic [NREG-1:0]    busy,
  output logic [5:0]         inflight_count
);

  import rv_pkg::*;

  localparam logic [NREG-1:0] C_ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0] r_busy;
  logic [5:0]      r_count;

  logic            w_alu_grant;
  logic            w_mem_grant;
  wb_src_e         w_last_grant;
  logic            w_wb_fire;
  reg_addr_t       w_wb_rd;
  logic [XLEN-1:0] w_wb_data;
  logic            w_hazard;
  logic            w_set;
  logic            w_clr;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_wb_mask;

  wb_rr_arbiter u_arb (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_wb_valid),
    .mem_valid  (mem_wb_valid),
    .alu_grant  (w_alu_grant),
    .mem_grant  (w_mem_grant),
    .last_grant (w_last_grant)
  );

  always_comb begin
    w_wb_fire  = w_alu_grant | w_mem_grant;
    w_wb_rd    = w_alu_grant ? alu_wb_rd   : mem_wb_rd;
    w_wb_data  = w_alu_grant ? alu_wb_data : mem_wb_data;

    // No bypass: a source being written this cycle is still busy until the edge.
    w_hazard   = r_busy[issue_rs1] | r_busy[issue_rs2] |
                 (issue_writes_rd & r_busy[issue_rd]);

    w_set      = issue_valid & ~w_hazard & issue_writes_rd & (issue_rd != '0);
    w_clr      = w_wb_fire & (w_wb_rd != '0) & r_busy[w_wb_rd];
    w_set_mask = w_set     ? (C_ONE << issue_rd) : '0;
    w_clr_mask = w_clr     ? (C_ONE << w_wb_rd)  : '0;
    w_wb_mask  = w_wb_fire ? (C_ONE << w_wb_rd)  : '0;
  end

  // Set is applied after clear so a same-index collision leaves the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= (r_busy & ~w_clr_mask) | w_set_mask;
      r_count <= r_count + {5'd0, w_set} - {5'd0, w_clr};
    end
  end

  assign issue_ready      = ~w_hazard;
  assign alu_wb_ready     = w_alu_grant;
  assign mem_wb_ready     = w_mem_grant;
  assign rf_write_address = w_wb_rd;
  assign rf_write_data    = w_wb_data;
  assign rf_write_enable  = w_wb_fire & (w_wb_rd != '0);
  assign busy             = r_busy;
  assign inflight_count   = r_count;

`ifndef SYNTHESIS
  // Registers in flight across a reset may legitimately write back un-busy.
  logic [NREG-1:0] r_orphan;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_orphan <= r_orphan | r_busy;
    end else begin
      r_orphan <= r_orphan & ~w_wb_mask & ~w_set_mask;
      if (w_wb_fire && (w_wb_rd != '0)) begin
        assert (r_busy[w_wb_rd] || r_orphan[w_wb_rd])
          else $error("writeback to non-busy register x%0d (last_grant=%0d)",
                      w_wb_rd, w_last_grant);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Scenario tasks plus a write-port scoreboard for regfile_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready, issue_writes_rd;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        alu_wb_valid, alu_wb_ready, mem_wb_valid, mem_wb_ready;
  logic [4:0]  alu_wb_rd, mem_wb_rd, rf_write_address;
  logic [31:0] alu_wb_data, mem_wb_data, rf_write_data;
  logic        rf_write_enable;
  logic [31:0] busy;
  logic [5:0]  inflight_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t         exp_q[$];
  logic [31:0] rf_model [32];

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk              (clk),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_rs1        (issue_rs1),
    .issue_rs2        (issue_rs2),
    .issue_rd         (issue_rd),
    .issue_writes_rd  (issue_writes_rd),
    .alu_wb_valid     (alu_wb_valid),
    .alu_wb_ready     (alu_wb_ready),
    .alu_wb_rd        (alu_wb_rd),
    .alu_wb_data      (alu_wb_data),
    .mem_wb_valid     (mem_wb_valid),
    .mem_wb_ready     (mem_wb_ready),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_data      (mem_wb_data),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .rf_write_enable  (rf_write_enable),
    .busy             (busy),
    .inflight_count   (inflight_count)
  );

  // Register file model: captures every write the DUT commits and checks it
  // against the next expected write.
  always @(negedge clk) begin
    if (!reset && rf_write_enable) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rf_write unexpected: addr=%0d data=%0d, required no write",
                 rf_write_address, rf_write_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_write_address !== e.addr || rf_write_data !== e.data) begin
          failures++;
          $display("FAIL rf_write: addr=%0d data=%0d, required addr=%0d data=%0d",
                   rf_write_address, rf_write_data, e.addr, e.data);
        end
      end
      rf_model[rf_write_address] = rf_write_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_writes_rd = 0;
    issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    mem_wb_valid = 0; mem_wb_rd = 0; mem_wb_data = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;
  endtask

  task automatic issue_write(input logic [4:0] rd);
    issue_valid = 1; issue_writes_rd = 1; issue_rd = rd;
    issue_rs1 = 0; issue_rs2 = 0;
    step();
    issue_valid = 0; issue_writes_rd = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    checks++; if (busy !== 32'h0) begin failures++;
      $display("FAIL reset_busy: got %h, required 0", busy); end
    checks++; if (inflight_count !== 6'd0) begin failures++;
      $display("FAIL reset_count: got %0d, required 0", inflight_count); end
    checks++; if (issue_ready !== 1'b1) begin failures++;
      $display("FAIL reset_ready: got %b, required 1", issue_ready); end
  endtask

  task automatic test_raw();
    issue_write(5'd5);
    #1;
    checks++; if (busy !== 32'h0000_0020) begin failures++;
      $display("FAIL raw_busy5: got %h, required 00000020", busy); end
    checks++; if (inflight_count !== 6'd1) begin failures++;
      $display("FAIL raw_count1: got %0d, required 1", inflight_count); end
    issue_valid = 1; issue_rs1 = 5; issue_writes_rd = 0;
    #1;
    checks++; if (issue_ready !== 1'b0) begin failures++;
      $display("FAIL raw_stall: got %b, required 0", issue_ready); end
    alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 32'd1234;
    exp_q.push_back('{5'd5, 32'd1234});
    #1;
    checks++; if (alu_wb_ready !== 1'b1 || rf_write_enable !== 1'b1 || rf_write_address !== 5'd5) begin
      failures++;
      $display("FAIL raw_wb: ready=%b en=%b addr=%0d, required 1 1 5",
               alu_wb_ready, rf_write_enable, rf_write_address); end
    checks++; if (issue_ready !== 1'b0) begin failures++;
      $display("FAIL raw_no_bypass: got %b, required 0", issue_ready); end
    step();
    alu_wb_valid = 0;
    #1;
    checks++; if (issue_ready !== 1'b1 || inflight_count !== 6'd0) begin failures++;
      $display("FAIL raw_release: ready=%b count=%0d, required 1 0", issue_ready, inflight_count); end
    checks++; if (rf_model[5] !== 32'd1234) begin failures++;
      $display("FAIL raw_rf_read: got %0d, required 1234", rf_model[5]); end
    step();
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic [4:0] alu_rds [2];
    logic [4:0] mem_rds [2];
    int ai = 0, mi = 0;
    logic       exp_alu;
    alu_rds[0] = 1; alu_rds[1] = 2;
    mem_rds[0] = 3; mem_rds[1] = 4;
    reset_dut();
    for (int r = 1; r <= 4; r++) issue_write(5'(r));
    #1;
    checks++; if (inflight_count !== 6'd4) begin failures++;
      $display("FAIL rr_count4: got %0d, required 4", inflight_count); end
    for (int c = 0; c < 4; c++) begin
      alu_wb_valid = (ai < 2); alu_wb_rd = alu_rds[ai % 2]; alu_wb_data = 32'd100 + 32'(alu_rds[ai % 2]);
      mem_wb_valid = (mi < 2); mem_wb_rd = mem_rds[mi % 2]; mem_wb_data = 32'd200 + 32'(mem_rds[mi % 2]);
      exp_alu = (c % 2 == 0);
      if (exp_alu) exp_q.push_back('{alu_wb_rd, alu_wb_data});
      else         exp_q.push_back('{mem_wb_rd, mem_wb_data});
      #1;
      checks++; if (alu_wb_ready !== exp_alu || mem_wb_ready !== !exp_alu) begin failures++;
        $display("FAIL rr_grant%0d: alu=%b mem=%b, required alu=%b mem=%b",
                 c, alu_wb_ready, mem_wb_ready, exp_alu, !exp_alu); end
      step();
      if (exp_alu) ai++; else mi++;
    end
    idle_inputs();
    #1;
    checks++; if (busy !== 32'h0 || inflight_count !== 6'd0) begin failures++;
      $display("FAIL rr_drained: busy=%h count=%0d, required 0 0", busy, inflight_count); end
  endtask

  task automatic test_waw();
    issue_write(5'd7);
    issue_valid = 1; issue_rd = 7; issue_writes_rd = 1; issue_rs1 = 1; issue_rs2 = 2;
    #1;
    checks++; if (issue_ready !== 1'b0) begin failures++;
      $display("FAIL waw_stall: got %b, required 0", issue_ready); end
    issue_writes_rd = 0;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++;
      $display("FAIL waw_nowrite_ready: got %b, required 1", issue_ready); end
    issue_valid = 0;
    alu_wb_valid = 1; alu_wb_rd = 7; alu_wb_data = 32'hCAFE_0007;
    exp_q.push_back('{5'd7, 32'hCAFE_0007});
    step();
    idle_inputs();
    #1;
    checks++; if (inflight_count !== 6'd0) begin failures++;
      $display("FAIL waw_clear: got %0d, required 0", inflight_count); end
  endtask

  task automatic test_wb_x0();
    mem_wb_valid = 1; mem_wb_rd = 0; mem_wb_data = 32'd5678;
    #1;
    checks++; if (mem_wb_ready !== 1'b1 || rf_write_enable !== 1'b0) begin failures++;
      $display("FAIL x0_wb: ready=%b en=%b, required 1 0", mem_wb_ready, rf_write_enable); end
    step();
    idle_inputs();
    #1;
    checks++; if (rf_model[0] !== 32'd0 || inflight_count !== 6'd0) begin failures++;
      $display("FAIL x0_read: x0=%0d count=%0d, required 0 0", rf_model[0], inflight_count); end
  endtask

  task automatic test_reset_midflight();
    issue_write(5'd9);
    #1;
    checks++; if (inflight_count !== 6'd1) begin failures++;
      $display("FAIL mid_count1: got %0d, required 1", inflight_count); end
    reset = 1; step(); step(); reset = 0;
    #1;
    checks++; if (busy !== 32'h0 || inflight_count !== 6'd0) begin failures++;
      $display("FAIL mid_reset: busy=%h count=%0d, required 0 0", busy, inflight_count); end
    alu_wb_valid = 1; alu_wb_rd = 9; alu_wb_data = 32'd999;
    exp_q.push_back('{5'd9, 32'd999});
    #1;
    checks++; if (rf_write_enable !== 1'b1 || rf_write_address !== 5'd9) begin failures++;
      $display("FAIL mid_wb: en=%b addr=%0d, required 1 9", rf_write_enable, rf_write_address); end
    step();
    idle_inputs();
    #1;
    checks++; if (inflight_count !== 6'd0 || rf_model[9] !== 32'd999) begin failures++;
      $display("FAIL mid_after: count=%0d x9=%0d, required 0 999", inflight_count, rf_model[9]); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    idle_inputs();
    reset = 1;
    test_reset();
    test_raw();
    test_round_robin();
    test_waw();
    test_wb_x0();
    test_reset_midflight();
    step();
    checks++; if (exp_q.size() != 0) begin failures++;
      $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
